// File: rtl/svm_conflict_if.sv
// svm_conflict_if: transaction, batch-table update and statistics signals of svm_conflict_manager.
interface svm_conflict_if #(parameter int MAX_DEPENDENCIES = 256);
    logic                        txn_valid;
    logic [MAX_DEPENDENCIES-1:0] txn_read_deps;
    logic [MAX_DEPENDENCIES-1:0] txn_write_deps;
    logic [63:0]                 txn_owner_id;
    logic                        has_conflict;
    logic [2:0]                  conflict_type;
    logic                        new_batch_valid;
    logic [3:0]                  new_batch_id;
    logic [MAX_DEPENDENCIES-1:0] new_batch_read_deps;
    logic [MAX_DEPENDENCIES-1:0] new_batch_write_deps;
    logic [63:0]                 new_batch_owner_id;
    logic                        batch_completed;
    logic [3:0]                  batch_id;
    logic [MAX_DEPENDENCIES-1:0] global_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] global_write_dependencies;
    logic [31:0]                 global_conflicts;
    logic [31:0]                 raw_conflict_count;
    logic [31:0]                 waw_conflict_count;
    logic [31:0]                 war_conflict_count;
    modport master (
        output txn_valid, txn_read_deps, txn_write_deps, txn_owner_id,
        output new_batch_valid, new_batch_id, new_batch_read_deps, new_batch_write_deps, new_batch_owner_id,
        output batch_completed, batch_id,
        input  has_conflict, conflict_type, global_read_dependencies, global_write_dependencies,
        input  global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count
    );
    modport slave (
        input  txn_valid, txn_read_deps, txn_write_deps, txn_owner_id,
        input  new_batch_valid, new_batch_id, new_batch_read_deps, new_batch_write_deps, new_batch_owner_id,
        input  batch_completed, batch_id,
        output has_conflict, conflict_type, global_read_dependencies, global_write_dependencies,
        output global_conflicts, raw_conflict_count, waw_conflict_count, war_conflict_count
    );
endinterface

// File: rtl/svm_conflict_manager.sv
// svm_conflict_manager: in-flight batch table with RAW/WAW/WAR conflict flagging and counters.
// Define CM_OWNER_EXEMPT_EN to exclude a transaction's own batches from conflict detection.
module svm_conflict_manager #(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int MAX_BATCHES      = 16
) (
    input logic         clk,
    input logic         rst_n,
    svm_conflict_if.slave bus
);
    logic [MAX_BATCHES-1:0]      vld;
    logic [MAX_BATCHES-1:0]      part;
    logic [MAX_DEPENDENCIES-1:0] rd [MAX_BATCHES];
    logic [MAX_DEPENDENCIES-1:0] wr [MAX_BATCHES];
    logic [MAX_DEPENDENCIES-1:0] g_rd, g_wr, d_rd, d_wr;
    logic [2:0]                  ct;
    logic [31:0]                 gc, raw, waw, war;
`ifdef CM_OWNER_EXEMPT_EN
    logic [63:0] own [MAX_BATCHES];
    always_comb begin
        part = '0;
        for (int i = 0; i < MAX_BATCHES; i++)
            part[i] = vld[i] && own[i] != bus.txn_owner_id;
    end
`else
    logic unused_owner;
    assign unused_owner = ^{bus.txn_owner_id, bus.new_batch_owner_id};
    assign part = vld;
`endif
    // Completion is applied first so a same-index registration overrides it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            gc  <= '0;
            raw <= '0;
            waw <= '0;
            war <= '0;
        end else begin
            for (int i = 0; i < MAX_BATCHES; i++) begin
                if (bus.batch_completed && bus.batch_id == 4'(i))
                    vld[i] <= 1'b0;
                if (bus.new_batch_valid && bus.new_batch_id == 4'(i)) begin
                    vld[i] <= 1'b1;
                    rd[i]  <= bus.new_batch_read_deps;
                    wr[i]  <= bus.new_batch_write_deps;
`ifdef CM_OWNER_EXEMPT_EN
                    own[i] <= bus.new_batch_owner_id;
`endif
                end
            end
            if (|ct) begin
                gc  <= gc + 32'd1;
                raw <= raw + 32'(ct[2]);
                waw <= waw + 32'(ct[1]);
                war <= war + 32'(ct[0]);
            end
        end
    end
    always_comb begin
        g_rd = '0;
        g_wr = '0;
        d_rd = '0;
        d_wr = '0;
        for (int i = 0; i < MAX_BATCHES; i++) begin
            g_rd = g_rd | (vld[i] ? rd[i] : '0);
            g_wr = g_wr | (vld[i] ? wr[i] : '0);
            d_rd = d_rd | (part[i] ? rd[i] : '0);
            d_wr = d_wr | (part[i] ? wr[i] : '0);
        end
    end
    assign ct = bus.txn_valid ? {|(bus.txn_read_deps & d_wr), |(bus.txn_write_deps & d_wr),
                                 |(bus.txn_write_deps & d_rd)} : 3'b000;
    assign bus.conflict_type             = ct;
    assign bus.has_conflict              = |ct;
    assign bus.global_read_dependencies  = g_rd;
    assign bus.global_write_dependencies = g_wr;
    assign bus.global_conflicts          = gc;
    assign bus.raw_conflict_count        = raw;
    assign bus.waw_conflict_count        = waw;
    assign bus.war_conflict_count        = war;
endmodule

// File: tb/tb_svm_conflict_manager.sv
// tb_svm_conflict_manager: table-driven check of svm_conflict_manager (8-entry table, 256-bit masks).
module tb_svm_conflict_manager;
    localparam logic [255:0] Z = '0;
    typedef struct {
        logic         tv;
        logic [255:0] trd, twr;
        logic [63:0]  town;
        logic         nbv;
        logic [3:0]   nid;
        logic [255:0] nrd, nwr;
        logic [63:0]  nown;
        logic         bc;
        logic [3:0]   bid;
        logic [2:0]   ct;
        logic [255:0] grd, gwr;
        logic [31:0]  gc, raw, waw, war;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t v [$];
    logic [2:0] own_ct;

    svm_conflict_if #(.MAX_DEPENDENCIES(256)) bus ();
    svm_conflict_manager #(.MAX_DEPENDENCIES(256), .MAX_BATCHES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [255:0] b(input int n);
        return 256'(1) << n;
    endfunction

    function automatic vec_t mk(input bit tv, input logic [255:0] trd, twr, input int town,
                                input bit nbv, input int nid, input logic [255:0] nrd, nwr, input int nown,
                                input bit bc, input int bid, input logic [2:0] ct, input logic [255:0] grd, gwr,
                                input int gc, raw, waw, war);
        vec_t e;
        e.tv = tv; e.trd = trd; e.twr = twr; e.town = 64'(town);
        e.nbv = nbv; e.nid = 4'(nid); e.nrd = nrd; e.nwr = nwr; e.nown = 64'(nown);
        e.bc = bc; e.bid = 4'(bid); e.ct = ct; e.grd = grd; e.gwr = gwr;
        e.gc = 32'(gc); e.raw = 32'(raw); e.waw = 32'(waw); e.war = 32'(war);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t e);
        bus.txn_valid = e.tv; bus.txn_read_deps = e.trd; bus.txn_write_deps = e.twr; bus.txn_owner_id = e.town;
        bus.new_batch_valid = e.nbv; bus.new_batch_id = e.nid; bus.new_batch_read_deps = e.nrd;
        bus.new_batch_write_deps = e.nwr; bus.new_batch_owner_id = e.nown;
        bus.batch_completed = e.bc; bus.batch_id = e.bid;
    endtask

    // Combinational outputs checked before the edge, counters just after it.
    task automatic apply(input vec_t e, input string tag);
        drive(e);
        #1;
        chk({tag, ".ct"}, 256'(bus.conflict_type), 256'(e.ct));
        chk({tag, ".hc"}, 256'(bus.has_conflict), 256'(|e.ct));
        chk({tag, ".grd"}, bus.global_read_dependencies, e.grd);
        chk({tag, ".gwr"}, bus.global_write_dependencies, e.gwr);
        @(posedge clk);
        #1;
        chk({tag, ".gc"}, 256'(bus.global_conflicts), 256'(e.gc));
        chk({tag, ".raw"}, 256'(bus.raw_conflict_count), 256'(e.raw));
        chk({tag, ".waw"}, 256'(bus.waw_conflict_count), 256'(e.waw));
        chk({tag, ".war"}, 256'(bus.war_conflict_count), 256'(e.war));
    endtask

    initial begin
        //          tv    trd         twr         town nbv   nid nrd     nwr     nown bc    bid ct      grd     gwr        gc raw waw war
        v.push_back(mk(1'b1, b(5),       Z,          0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b000, Z,      Z,         0, 0, 0, 0));
        v.push_back(mk(1'b0, Z,          Z,          0, 1'b1, 2, b(3),   b(7),   1, 1'b0, 0, 3'b000, Z,      Z,         0, 0, 0, 0));
        v.push_back(mk(1'b1, b(7),       Z,          0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b100, b(3),   b(7),      1, 1, 0, 0));
        v.push_back(mk(1'b1, Z,          b(3)|b(7),  0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b011, b(3),   b(7),      2, 1, 1, 1));
        v.push_back(mk(1'b1, b(7),       b(3)|b(7),  0, 1'b0, 0, Z,      Z,      1, 1'b1, 2, 3'b111, b(3),   b(7),      3, 2, 2, 2));
        v.push_back(mk(1'b1, b(7),       b(3)|b(7),  0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b000, Z,      Z,         3, 2, 2, 2));
        v.push_back(mk(1'b1, b(7),       Z,          0, 1'b1, 4, Z,      b(7),   1, 1'b0, 0, 3'b000, Z,      Z,         3, 2, 2, 2));
        v.push_back(mk(1'b0, b(7),       Z,          0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b000, Z,      b(7),      3, 2, 2, 2));
        v.push_back(mk(1'b0, Z,          Z,          0, 1'b1, 1, b(10),  Z,      1, 1'b1, 1, 3'b000, Z,      b(7),      3, 2, 2, 2));
        v.push_back(mk(1'b1, Z,          b(10),      0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b001, b(10),  b(7),      4, 2, 2, 3));
        v.push_back(mk(1'b0, Z,          Z,          0, 1'b1, 15, Z,     b(20),  1, 1'b1, 12, 3'b000, b(10), b(7),      4, 2, 2, 3));
        v.push_back(mk(1'b1, b(20),      Z,          0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b000, b(10),  b(7),      4, 2, 2, 3));
        v.push_back(mk(1'b0, Z,          Z,          0, 1'b1, 4, Z,      b(8),   1, 1'b1, 1, 3'b000, b(10),  b(7),      4, 2, 2, 3));
        v.push_back(mk(1'b1, b(7)|b(8),  Z,          0, 1'b0, 0, Z,      Z,      1, 1'b0, 0, 3'b100, Z,      b(8),      5, 3, 2, 3));

        // A registration presented during reset must be discarded.
        rst_n = 1'b0;
        drive(mk(1'b0, Z, Z, 0, 1'b1, 0, b(1), b(1), 1, 1'b0, 0, 3'b000, Z, Z, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        foreach (v[i]) apply(v[i], $sformatf("v%0d", i));

        // Owner exemption: same owner is exempt only when the feature is built in.
`ifdef CM_OWNER_EXEMPT_EN
        own_ct = 3'b000;
`else
        own_ct = 3'b100;
`endif
        apply(mk(1'b0, Z, Z, 0, 1'b1, 3, Z, b(9), 42, 1'b0, 0, 3'b000, Z, b(8), 5, 3, 2, 3), "own_reg");
        apply(mk(1'b1, b(9), Z, 42, 1'b0, 0, Z, Z, 0, 1'b0, 0, own_ct, Z, b(8)|b(9),
                 5 + int'(own_ct[2]), 3 + int'(own_ct[2]), 2, 3), "own42");
        apply(mk(1'b1, b(9), Z, 43, 1'b0, 0, Z, Z, 0, 1'b0, 0, 3'b100, Z, b(8)|b(9),
                 6 + int'(own_ct[2]), 4 + int'(own_ct[2]), 2, 3), "own43");

        // Mid-run reset clears table and counters, discarding a same-cycle registration.
        rst_n = 1'b0;
        drive(mk(1'b1, b(9), Z, 43, 1'b1, 5, Z, b(30), 1, 1'b0, 0, 3'b000, Z, Z, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(1'b1, b(9)|b(30), b(8), 0, 1'b0, 0, Z, Z, 0, 1'b0, 0, 3'b000, Z, Z, 0, 0, 0, 0), "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/svm_conflict_manager.md
# svm_conflict_manager

Global dependency tracker for the SVM hardware scheduler. It keeps one entry per in-flight batch, each holding a read mask, a write mask and an owner. It forms the global read/write dependency unions and flags any incoming transaction whose dependencies collide with an active batch. It sits between the input AXI-Stream demux and the parallel batcher instances; the top level drops transactions it flags.

## Interface
Parameters:
- MAX_DEPENDENCIES, 256: width of every dependency bit-mask.
- MAX_BATCHES, 16: number of batch-table entries; legal range 1..16.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- txn_valid  in  1  candidate transaction present.
- txn_read_deps  in  MAX_DEPENDENCIES  transaction read set.
- txn_write_deps  in  MAX_DEPENDENCIES  transaction write set.
- txn_owner_id  in  64  transaction owner program ID.
- has_conflict  out  1  combinational conflict flag.
- conflict_type  out  3  combinational conflict kind: bit 2 = RAW, bit 1 = WAW, bit 0 = WAR.
- new_batch_valid  in  1  register a batch this cycle.
- new_batch_id  in  4  table index of the new batch.
- new_batch_read_deps  in  MAX_DEPENDENCIES  read union of the new batch.
- new_batch_write_deps  in  MAX_DEPENDENCIES  write union of the new batch.
- new_batch_owner_id  in  64  owner of the new batch.
- batch_completed  in  1  release a batch this cycle.
- batch_id  in  4  table index of the completed batch.
- global_read_dependencies  out  MAX_DEPENDENCIES  OR of read masks across valid entries.
- global_write_dependencies  out  MAX_DEPENDENCIES  OR of write masks across valid entries.
- global_conflicts  out  32  count of flagged transactions.
- raw_conflict_count  out  32  RAW event count.
- waw_conflict_count  out  32  WAW event count.
- war_conflict_count  out  32  WAR event count.

## Operation
- Table: MAX_BATCHES entries. Each entry holds valid, rd[MAX_DEPENDENCIES-1:0], wr[MAX_DEPENDENCIES-1:0] and owner[63:0].
- Global unions: bitwise OR of rd (respectively wr) over all valid entries. Both unions are 0 when the table is empty.
- Conflict detection, computed against the current (registered) table state:
  - RAW = |(txn_read_deps & global_write).
  - WAW = |(txn_write_deps & global_write).
  - WAR = |(txn_write_deps & global_read).
  - Any combination of the three bits may be set together.
- conflict_type = {RAW, WAW, WAR} gated by txn_valid.
- has_conflict = |conflict_type. Both outputs are 0 whenever txn_valid is 0.
- Registration: when new_batch_valid = 1, entry[new_batch_id] is loaded with valid = 1 and the new deps and owner. A valid entry is overwritten.
- Completion: when batch_completed = 1, entry[batch_id].valid is cleared. Completing an already-invalid entry has no effect.
- Index range: any index >= MAX_BATCHES is ignored for both registration and completion.
- Simultaneous registration and completion:
  - Same index: registration wins, so the entry ends valid with the new contents.
  - Different indices: both operations are applied.
- Counters: in each cycle with has_conflict = 1:
  - global_conflicts increments by 1.
  - raw_conflict_count, waw_conflict_count and war_conflict_count each increment by 1 when their conflict_type bit is set.
  - All four counters wrap modulo 2^32.

## Timing
- Reset, while rst_n = 0 at a clock edge:
  - all entries become invalid; all counters become 0.
  - global unions read 0; has_conflict and conflict_type read 0.
  - registration and completion requests in reset cycles are discarded.
- has_conflict, conflict_type and the global unions are combinational from the table state and txn_* inputs, with zero-cycle latency.
- A registration or completion at edge N is visible in the unions and in conflict detection from cycle N+1.
- A transaction presented in the same cycle as a registration is checked against the pre-registration table.
- Counters update at the edge that ends the conflicting cycle.
- No handshake: the block never stalls, and each cycle with txn_valid = 1 is an independent check.

## Configuration
- Macro CM_OWNER_EXEMPT_EN.
- Defined: a valid entry whose owner equals txn_owner_id is excluded from the unions used for conflict detection. A program does not conflict with its own batches. The global_*_dependencies outputs still include all valid entries.
- Undefined: owner is stored but ignored. Every valid entry participates in detection, and txn_owner_id has no effect.

## Test plan
- Reset then idle: txn_valid = 1 with read bit 5 -> has_conflict = 0, unions = 0, all counters 0.
- Register id 2 with wr = bit 7; next cycle send a txn with rd = bit 7 -> conflict_type = 3'b100, has_conflict = 1; after the edge global_conflicts = 1 and raw_conflict_count = 1.
- Table holds id 2 (rd = bit 3, wr = bit 7); send a txn with wr = bits 3 and 7 -> conflict_type = 3'b011; waw_conflict_count and war_conflict_count each +1.
- Complete id 2 -> next cycle unions = 0, and the same txn gives has_conflict = 0.
- Same-cycle registration of id 1 and completion of id 1 -> entry 1 valid next cycle. Registration of id 15 with MAX_BATCHES = 8 is ignored, so unions are unchanged.
- With CM_OWNER_EXEMPT_EN: register owner 42 with wr = bit 9; a txn from owner 42 with rd = bit 9 -> no conflict; the same txn from owner 43 -> RAW.
